// File: rtl/centroid_tracker_if.sv
// Pixel-stream inputs and centroid result outputs of centroid_tracker; bbox outputs
// exist only when CENTROID_TRACKER_BBOX_EN is defined.
interface centroid_tracker_if #(
  parameter int CW = 10
);
  logic          ce;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          mask;
  logic [CW-1:0]   x;
  logic [CW-1:0]   y;
  logic [2*CW-1:0] area;
  logic          valid;
  logic          lost;
  logic          busy;
  logic          overrun;
`ifdef CENTROID_TRACKER_BBOX_EN
  logic [CW-1:0] x_min;
  logic [CW-1:0] x_max;
  logic [CW-1:0] y_min;
  logic [CW-1:0] y_max;

  modport slave (
    input  ce, de, hsync, vsync, mask,
    output x, y, area, valid, lost, busy, overrun, x_min, x_max, y_min, y_max
  );
  modport master (
    output ce, de, hsync, vsync, mask,
    input  x, y, area, valid, lost, busy, overrun, x_min, x_max, y_min, y_max
  );
`else
  modport slave (
    input  ce, de, hsync, vsync, mask,
    output x, y, area, valid, lost, busy, overrun
  );
  modport master (
    output ce, de, hsync, vsync, mask,
    input  x, y, area, valid, lost, busy, overrun
  );
`endif
endinterface

// File: rtl/centroid_tracker.sv
// Per-frame mask centroid via moment sums and a CW-cycle restoring divide; valid lands CW+3
// clocks after the eof pixel (3 when lost). No backpressure. Bbox outputs: CENTROID_TRACKER_BBOX_EN.
module centroid_tracker #(
  parameter int IMG_W    = 720,
  parameter int IMG_H    = 576,
  parameter int CW       = 10,
  parameter int MIN_AREA = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  centroid_tracker_if.slave bus
);
  localparam int AW = 2 * CW;
  localparam int SW = 3 * CW;
  localparam int NW = $clog2(CW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic          eof_q, eof_d;
  logic [AW-1:0] m00_q, m00_d, s00_q, s00_d;
  logic [SW-1:0] m10_q, m10_d, m01_q, m01_d, s10_q, s10_d, s01_q, s01_d;
  logic [AW-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [CW-1:0] nx_q, nx_d, ny_q, ny_d, qx_q, qx_d, qy_q, qy_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          miss_q, miss_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0] area_q, area_d;
  logic          valid_q, valid_d, lost_q, lost_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [AW:0]   stx, sty;
  logic          accept, last_x, last_y;
`ifdef CENTROID_TRACKER_BBOX_EN
  logic [CW-1:0] tx0_q, tx0_d, tx1_q, tx1_d, ty0_q, ty0_d, ty1_q, ty1_d;
  logic [CW-1:0] sx0_q, sx0_d, sx1_q, sx1_d, sy0_q, sy0_d, sy1_q, sy1_d;
  logic [CW-1:0] xmn_q, xmn_d, xmx_q, xmx_d, ymn_q, ymn_d, ymx_q, ymx_d;
`endif

  // One restoring step: returns {quotient bit, new remainder}.
  function automatic logic [AW:0] div_step(input logic [AW-1:0] rem, input logic nbit,
                                           input logic [AW-1:0] den);
    logic [AW:0] trial;
    trial = {rem, nbit};
    if (trial >= {1'b0, den}) div_step = {1'b1, AW'(trial - {1'b0, den})};
    else                      div_step = {1'b0, trial[AW-1:0]};
  endfunction

  assign accept = bus.ce & bus.de & bus.vsync;
  assign last_x = (cx_q == CW'(IMG_W - 1));
  assign last_y = (cy_q == CW'(IMG_H - 1));
  assign stx    = div_step(rx_q, nx_q[CW-1], s00_q);
  assign sty    = div_step(ry_q, ny_q[CW-1], s00_q);

  always_comb begin
    state_d = state_q;  cx_d = cx_q;    cy_d = cy_q;    eof_d = 1'b0;
    m00_d = m00_q;      m10_d = m10_q;  m01_d = m01_q;
    s00_d = s00_q;      s10_d = s10_q;  s01_d = s01_q;
    rx_d = rx_q;  ry_d = ry_q;  nx_d = nx_q;  ny_d = ny_q;  qx_d = qx_q;  qy_d = qy_q;
    cnt_d = cnt_q;  miss_d = miss_q;  x_d = x_q;  y_d = y_q;  area_d = area_q;
    valid_d = 1'b0;  lost_d = lost_q;  busy_d = busy_q;  overrun_d = 1'b0;
`ifdef CENTROID_TRACKER_BBOX_EN
    tx0_d = tx0_q;  tx1_d = tx1_q;  ty0_d = ty0_q;  ty1_d = ty1_q;
    sx0_d = sx0_q;  sx1_d = sx1_q;  sy0_d = sy0_q;  sy1_d = sy1_q;
    xmn_d = xmn_q;  xmx_d = xmx_q;  ymn_d = ymn_q;  ymx_d = ymx_q;
`endif

    // The clock after eof restarts the sums; a pixel in that clock joins the new frame.
    if (eof_q) begin
      m00_d = '0;  m10_d = '0;  m01_d = '0;
`ifdef CENTROID_TRACKER_BBOX_EN
      tx0_d = '1;  tx1_d = '0;  ty0_d = '1;  ty1_d = '0;
`endif
    end
    if (accept) begin
      eof_d = last_x & last_y;
      if (last_x) begin
        cx_d = '0;
        cy_d = last_y ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
      if (bus.mask) begin
        m00_d = m00_d + 1'b1;
        m10_d = m10_d + SW'(cx_q);
        m01_d = m01_d + SW'(cy_q);
`ifdef CENTROID_TRACKER_BBOX_EN
        if (cx_q < tx0_d) tx0_d = cx_q;
        if (cx_q > tx1_d) tx1_d = cx_q;
        if (cy_q < ty0_d) ty0_d = cy_q;
        if (cy_q > ty1_d) ty1_d = cy_q;
`endif
      end
    end
    if (!bus.vsync) begin
      cx_d = '0;  cy_d = '0;  m00_d = '0;  m10_d = '0;  m01_d = '0;
`ifdef CENTROID_TRACKER_BBOX_EN
      tx0_d = '1;  tx1_d = '0;  ty0_d = '1;  ty1_d = '0;
`endif
    end

    case (state_q)
      IDLE: if (eof_q) begin
        s00_d = m00_q;  s10_d = m10_q;  s01_d = m01_q;
`ifdef CENTROID_TRACKER_BBOX_EN
        sx0_d = tx0_q;  sx1_d = tx1_q;  sy0_d = ty0_q;  sy1_d = ty1_q;
`endif
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d = '0;
        if (s00_q < AW'(MIN_AREA)) begin
          miss_d  = 1'b1;
          state_d = DONE;
        end else begin
          // Centroid fits CW bits, so the upper dividend bits are already below the divisor.
          miss_d  = 1'b0;
          rx_d = s10_q[SW-1:CW];  nx_d = s10_q[CW-1:0];
          ry_d = s01_q[SW-1:CW];  ny_d = s01_q[CW-1:0];
          state_d = DIV;
        end
      end
      DIV: begin
        rx_d = stx[AW-1:0];  qx_d = {qx_q[CW-2:0], stx[AW]};  nx_d = nx_q << 1;
        ry_d = sty[AW-1:0];  qy_d = {qy_q[CW-2:0], sty[AW]};  ny_d = ny_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == NW'(CW - 1)) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        area_d  = s00_q;
        lost_d  = miss_q;
        if (!miss_q) begin
          x_d = qx_q;  y_d = qy_q;
`ifdef CENTROID_TRACKER_BBOX_EN
          xmn_d = sx0_q;  xmx_d = sx1_q;  ymn_d = sy0_q;  ymx_d = sy1_q;
`endif
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (eof_q && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;  cx_q <= '0;  cy_q <= '0;  eof_q <= 1'b0;
      m00_q <= '0;  m10_q <= '0;  m01_q <= '0;  s00_q <= '0;  s10_q <= '0;  s01_q <= '0;
      rx_q <= '0;  ry_q <= '0;  nx_q <= '0;  ny_q <= '0;  qx_q <= '0;  qy_q <= '0;
      cnt_q <= '0;  miss_q <= 1'b0;  x_q <= '0;  y_q <= '0;  area_q <= '0;
      valid_q <= 1'b0;  lost_q <= 1'b0;  busy_q <= 1'b0;  overrun_q <= 1'b0;
`ifdef CENTROID_TRACKER_BBOX_EN
      tx0_q <= '1;  tx1_q <= '0;  ty0_q <= '1;  ty1_q <= '0;
      sx0_q <= '0;  sx1_q <= '0;  sy0_q <= '0;  sy1_q <= '0;
      xmn_q <= '0;  xmx_q <= '0;  ymn_q <= '0;  ymx_q <= '0;
`endif
    end else begin
      state_q <= state_d;  cx_q <= cx_d;  cy_q <= cy_d;  eof_q <= eof_d;
      m00_q <= m00_d;  m10_q <= m10_d;  m01_q <= m01_d;  s00_q <= s00_d;  s10_q <= s10_d;  s01_q <= s01_d;
      rx_q <= rx_d;  ry_q <= ry_d;  nx_q <= nx_d;  ny_q <= ny_d;  qx_q <= qx_d;  qy_q <= qy_d;
      cnt_q <= cnt_d;  miss_q <= miss_d;  x_q <= x_d;  y_q <= y_d;  area_q <= area_d;
      valid_q <= valid_d;  lost_q <= lost_d;  busy_q <= busy_d;  overrun_q <= overrun_d;
`ifdef CENTROID_TRACKER_BBOX_EN
      tx0_q <= tx0_d;  tx1_q <= tx1_d;  ty0_q <= ty0_d;  ty1_q <= ty1_d;
      sx0_q <= sx0_d;  sx1_q <= sx1_d;  sy0_q <= sy0_d;  sy1_q <= sy1_d;
      xmn_q <= xmn_d;  xmx_q <= xmx_d;  ymn_q <= ymn_d;  ymx_q <= ymx_d;
`endif
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.area    = area_q;
  assign bus.valid   = valid_q;
  assign bus.lost    = lost_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
`ifdef CENTROID_TRACKER_BBOX_EN
  assign bus.x_min   = xmn_q;
  assign bus.x_max   = xmx_q;
  assign bus.y_min   = ymn_q;
  assign bus.y_max   = ymx_q;
`endif
endmodule

// File: tb/tb_centroid_tracker.sv
// Directed frames on a 16x8 image: square, empty, column, gapped square, vsync abort
// and a reset during the divide, each checked against hand-computed results.
module tb_centroid_tracker;
  localparam int W   = 16;
  localparam int H   = 8;
  localparam int CW  = 5;
  localparam int MA  = 4;
  localparam int LAT = CW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  centroid_tracker_if #(.CW(CW)) bus();

  centroid_tracker #(.IMG_W(W), .IMG_H(H), .CW(CW), .MIN_AREA(MA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eof_edge = 0;
  int vcount = 0;
  int vcyc = 0;
  int ocount = 0;
  int vx = 0, vy = 0, varea = 0, vlost = 0;
  int v0;
`ifdef CENTROID_TRACKER_BBOX_EN
  int vx0 = 0, vx1 = 0, vy0 = 0, vy1 = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid) begin
      vcount++;
      vcyc  = cyc;
      vx    = int'(bus.x);
      vy    = int'(bus.y);
      varea = int'(bus.area);
      vlost = int'(bus.lost);
`ifdef CENTROID_TRACKER_BBOX_EN
      vx0 = int'(bus.x_min);  vx1 = int'(bus.x_max);
      vy0 = int'(bus.y_min);  vy1 = int'(bus.y_max);
`endif
    end
    if (bus.overrun) ocount++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_pixel(input logic m, input logic c, input logic d);
    bus.mask = m;  bus.ce = c;  bus.de = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.mask = 1'b0;  bus.ce = 1'b0;  bus.de = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic pix(input int kind, input int c, input int r);
    case (kind)
      0:       return (c >= 4 && c <= 7 && r >= 2 && r <= 5);
      1:       return (c == 15);
      default: return 1'b0;
    endcase
  endfunction

  // kind: 0 square, 1 column, 2 empty; gaps inserts ce-low cycles and masked de-low cycles.
  task automatic run_frame(input int kind, input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) begin
          drive_pixel(pix(kind, c, r), 1'b0, 1'b1);
          if (c % 5 == 2) drive_pixel(1'b1, 1'b1, 1'b0);
        end
        drive_pixel(pix(kind, c, r), 1'b1, 1'b1);
      end
    end
    eof_edge = cyc;
    idle(20);
  endtask

  task automatic check_result(input string tag, input int vbase, input int e_area,
                              input int e_x, input int e_y, input int e_lost, input int e_lat);
    chk({tag, "_valid_count"}, vcount - vbase, 1);
    chk({tag, "_area"}, varea, e_area);
    chk({tag, "_x"}, vx, e_x);
    chk({tag, "_y"}, vy, e_y);
    chk({tag, "_lost"}, vlost, e_lost);
    chk({tag, "_latency"}, vcyc - eof_edge, e_lat);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_x"}, int'(bus.x), 0);
    chk({tag, "_y"}, int'(bus.y), 0);
    chk({tag, "_area"}, int'(bus.area), 0);
    chk({tag, "_valid"}, int'(bus.valid), 0);
    chk({tag, "_lost"}, int'(bus.lost), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_overrun"}, int'(bus.overrun), 0);
`ifdef CENTROID_TRACKER_BBOX_EN
    chk({tag, "_x_min"}, int'(bus.x_min), 0);
    chk({tag, "_y_max"}, int'(bus.y_max), 0);
`endif
  endtask

`ifdef CENTROID_TRACKER_BBOX_EN
  task automatic check_bbox(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_x_min"}, vx0, a);
    chk({tag, "_x_max"}, vx1, b);
    chk({tag, "_y_min"}, vy0, c);
    chk({tag, "_y_max"}, vy1, d);
  endtask
`endif

  initial begin
    bus.ce = 1'b0;  bus.de = 1'b0;  bus.hsync = 1'b0;  bus.vsync = 1'b1;  bus.mask = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Square 4..7 x 2..5: sums 88 and 56 over 16 pixels.
    v0 = vcount;
    run_frame(0, 1'b0);
    check_result("square", v0, 16, 5, 3, 0, LAT);
`ifdef CENTROID_TRACKER_BBOX_EN
    check_bbox("square", 4, 7, 2, 5);
`endif

    v0 = vcount;
    run_frame(2, 1'b0);
    check_result("empty", v0, 0, 5, 3, 1, 3);
`ifdef CENTROID_TRACKER_BBOX_EN
    check_bbox("empty", 4, 7, 2, 5);
`endif

    v0 = vcount;
    run_frame(1, 1'b0);
    check_result("column", v0, 8, 15, 3, 0, LAT);
`ifdef CENTROID_TRACKER_BBOX_EN
    check_bbox("column", 15, 15, 0, 7);
`endif

    v0 = vcount;
    run_frame(0, 1'b1);
    check_result("gapped", v0, 16, 5, 3, 0, LAT);

    // Partial frame of 20 masked pixels aborted by vsync, then a clean square.
    v0 = vcount;
    for (int i = 0; i < 20; i++) drive_pixel(1'b1, 1'b1, 1'b1);
    bus.vsync = 1'b0;
    drive_pixel(1'b1, 1'b1, 1'b1);
    drive_pixel(1'b0, 1'b0, 1'b0);
    bus.vsync = 1'b1;
    run_frame(0, 1'b0);
    check_result("vsync", v0, 16, 5, 3, 0, LAT);

    // Column frame, reset while its divide is in flight.
    v0 = vcount;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) drive_pixel(pix(1, c, r), 1'b1, 1'b1);
    idle(4);
    chk("middiv_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_zero("middiv_rst");
    idle(20);
    chk("middiv_no_valid", vcount - v0, 0);
    chk("middiv_busy_after", int'(bus.busy), 0);

    v0 = vcount;
    run_frame(0, 1'b0);
    check_result("post_rst", v0, 16, 5, 3, 0, LAT);
`ifdef CENTROID_TRACKER_BBOX_EN
    check_bbox("post_rst", 4, 7, 2, 5);
`endif

    chk("overrun_pulses", ocount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
